// File: rtl/dmem_lsu_ctrl_if.sv
// CPU-side request/response bus of the data-memory load/store sequencer.
interface dmem_lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer: byte/half/word CPU accesses onto a word-only synchronous memory,
// sub-word stores as read-modify-write. Define DMEM_LSU_BOUNDS_CHECK_EN to reject out-of-range addresses.
module dmem_lsu_ctrl #(
  parameter int unsigned MEMORY_SIZE = 2048,
  parameter int unsigned ADDR_WIDTH  = $clog2(MEMORY_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_lsu_ctrl_if.slave        cpu,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_MRG, S_WR, S_ERR} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [1:0]            lane_r;
  logic [1:0]            size_r;
  logic                  we_r;
  logic                  uns_r;
  logic [31:0]           wdata_r;

  logic        accept;
  logic        misaligned;
  logic        out_of_range;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

`ifdef DMEM_LSU_BOUNDS_CHECK_EN
  assign out_of_range = |cpu.req_addr[31:ADDR_WIDTH+2];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^cpu.req_addr[31:ADDR_WIDTH+2];
  assign out_of_range   = 1'b0;
`endif

  assign accept     = cpu.req_valid && (state == S_IDLE);
  assign misaligned = (cpu.req_size == 2'b11)
                   || ((cpu.req_size == 2'b01) && cpu.req_addr[0])
                   || ((cpu.req_size == 2'b10) && (cpu.req_addr[1:0] != 2'b00));

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (misaligned || out_of_range)                  state_nxt = S_ERR;
          else if (cpu.req_we && (cpu.req_size == 2'b10))  state_nxt = S_WR;
          else                                             state_nxt = S_RD;
        end
      end
      S_RD:    state_nxt = S_MRG;
      S_MRG:   state_nxt = we_r ? S_WR : S_IDLE;
      S_WR:    state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lane extraction and merge both work on the word returned for the RD cycle.
  always_comb begin
    lane_byte = 8'h00;
    unique case (lane_r)
      2'd0: lane_byte = mem_rdata[7:0];
      2'd1: lane_byte = mem_rdata[15:8];
      2'd2: lane_byte = mem_rdata[23:16];
      2'd3: lane_byte = mem_rdata[31:24];
      default: lane_byte = 8'h00;
    endcase
    lane_half = lane_r[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_ext = mem_rdata;
    if (size_r == 2'b00)
      load_ext = {{24{~uns_r & lane_byte[7]}}, lane_byte};
    else if (size_r == 2'b01)
      load_ext = {{16{~uns_r & lane_half[15]}}, lane_half};

    merged = mem_rdata;
    if (size_r == 2'b00) begin
      unique case (lane_r)
        2'd0: merged[7:0]   = wdata_r[7:0];
        2'd1: merged[15:8]  = wdata_r[7:0];
        2'd2: merged[23:16] = wdata_r[7:0];
        2'd3: merged[31:24] = wdata_r[7:0];
        default: merged = mem_rdata;
      endcase
    end else if (size_r == 2'b01) begin
      if (lane_r[1]) merged[31:16] = wdata_r[15:0];
      else           merged[15:0]  = wdata_r[15:0];
    end else begin
      merged = wdata_r;
    end
  end

  always_comb begin
    cpu.req_ready = (state == S_IDLE);
    mem_addr      = addr_r;
    mem_re        = (state == S_RD);
    mem_we        = (state == S_WR);
    mem_wdata     = (state == S_WR) ? wdata_r : '0;
    cpu.rsp_valid = ((state == S_MRG) && !we_r) || (state == S_WR) || (state == S_ERR);
    cpu.rsp_err   = (state == S_ERR);
    cpu.rsp_rdata = ((state == S_MRG) && !we_r) ? load_ext : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_r  <= '0;
      lane_r  <= '0;
      size_r  <= '0;
      we_r    <= 1'b0;
      uns_r   <= 1'b0;
      wdata_r <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_r  <= cpu.req_addr[ADDR_WIDTH+1:2];
        lane_r  <= cpu.req_addr[1:0];
        size_r  <= cpu.req_size;
        we_r    <= cpu.req_we;
        uns_r   <= cpu.req_uns;
        wdata_r <= cpu.req_wdata;
      end else if ((state == S_MRG) && we_r) begin
        wdata_r <= merged;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Self-checking bench for dmem_lsu_ctrl: directed cases then random traffic against a byte-level memory model.
module tb_dmem_lsu_ctrl;
  localparam int unsigned AW    = 11;
  localparam int unsigned DEPTH = 2048;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_lsu_ctrl_if bus ();
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_re;
  logic [31:0]   mem_wdata, mem_rdata;

  dmem_lsu_ctrl #(.MEMORY_SIZE(DEPTH)) dut (
    .clk(clk), .rst(rst), .cpu(bus),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int unsigned npass  = 0;
  int unsigned ntotal = 0;

  function automatic logic [31:0] init_word(input int unsigned i);
    if (i == 4) return 32'h11223344;
    if (i == 5) return 32'hAABBCCDD;
    return (i * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Single-port synchronous memory: write on we, otherwise read registered for the next cycle.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata_out);
    logic err;
    int unsigned idx, sh, nb, lat;
    logic [31:0] old, mask, v, newv, exp_rd, rd_obs;
    logic [AW-1:0] we_addr, re_addr;
    logic [31:0] we_data;
    logic err_obs;
    int rsp_k, we_k, re_k, n_we, n_re;

    err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
`ifdef DMEM_LSU_BOUNDS_CHECK_EN
    if (addr[31:AW+2] != 0) err = 1'b1;
`endif
    idx  = int'(addr[AW+1:2]);
    sh   = 8 * int'(addr[1:0]);
    nb   = 1 << size;
    old  = ref_mem[idx];
    mask = (nb >= 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * nb)) - 32'd1);
    v    = (old >> sh) & mask;
    if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
    newv   = (old & ~(mask << sh)) | ((wdata & mask) << sh);
    exp_rd = (err || we) ? 32'h0 : v;
    if (err)                     lat = 1;
    else if (we && size == 2'b10) lat = 1;
    else if (!we)                lat = 2;
    else                         lat = 3;

    @(negedge clk);
    check("ready_idle", 32'(bus.req_ready), 32'd1);
    check("rsp_pulse_end", {bus.rsp_rdata[30:0], bus.rsp_valid}, 32'd0);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_uns = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk);
    rsp_k = 0; we_k = 0; re_k = 0; n_we = 0; n_re = 0;
    rd_obs = '0; err_obs = 1'b0; we_addr = '0; re_addr = '0; we_data = '0;
    for (int k = 1; k <= 8 && rsp_k == 0; k++) begin
      @(negedge clk);
      // Busy-cycle inputs must be ignored, so feed junk while valid stays high.
      bus.req_addr = $urandom; bus.req_wdata = $urandom;
      bus.req_size = 2'($urandom); bus.req_we = 1'($urandom); bus.req_uns = 1'($urandom);
      check("busy_ready", 32'(bus.req_ready), 32'd0);
      if (mem_we) begin n_we++; we_k = k; we_addr = mem_addr; we_data = mem_wdata; end
      if (mem_re) begin n_re++; re_k = k; re_addr = mem_addr; end
      if (bus.rsp_valid) begin
        rsp_k = k; rd_obs = bus.rsp_rdata; err_obs = bus.rsp_err;
      end else begin
        check("rsp_idle_zero", {bus.rsp_rdata[31:1], bus.rsp_err}, 32'd0);
      end
    end
    bus.req_valid = 1'b0;

    check("rsp_latency", 32'(rsp_k), 32'(lat));
    check("rsp_err", 32'(err_obs), 32'(err));
    check("rsp_rdata", rd_obs, exp_rd);
    check("mem_re_count", 32'(n_re), (!err && !(we && size == 2'b10)) ? 32'd1 : 32'd0);
    check("mem_we_count", 32'(n_we), (!err && we) ? 32'd1 : 32'd0);
    if (n_re > 0) begin
      check("mem_re_cycle", 32'(re_k), 32'd1);
      check("mem_re_addr", 32'(re_addr), 32'(idx));
    end
    if (n_we > 0) begin
      check("mem_we_cycle", 32'(we_k), 32'(lat));
      check("mem_we_addr", 32'(we_addr), 32'(idx));
      check("mem_wdata", we_data, newv);
    end
    if (!err && we) ref_mem[idx] = newv;
    rdata_out = rd_obs;
  endtask

  logic [31:0] rd;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_uns = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp", {bus.rsp_rdata[29:0], bus.rsp_valid, bus.rsp_err}, 32'd0);
    check("rst_mem_strb", {30'd0, mem_we, mem_re}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd); check("lw_10", rd, 32'h11223344);
    run_req(1'b0, 2'b00, 1'b0, 32'h16, 32'h0, rd); check("lb_16", rd, 32'hFFFFFFBB);
    run_req(1'b0, 2'b00, 1'b1, 32'h16, 32'h0, rd); check("lbu_16", rd, 32'h000000BB);
    run_req(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, rd); check("lh_16", rd, 32'hFFFFAABB);
    run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd); check("lhu_12", rd, 32'h00001122);
    run_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h5555AAAA, rd);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd); check("lw_10_after_err", rd, 32'h11223344);
    run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hDEADBEEE, rd);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd); check("lw_10_after_sb", rd, 32'h1122EE44);
    run_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h01020304, rd);
    run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd); check("lw_14_after_sw", rd, 32'h01020304);
    run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd);
    run_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, rd);

    // Reset in the middle of a sub-word store must drop the write and the response.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_uns = 1'b0; bus.req_addr = 32'h14; bus.req_wdata = 32'h000000FF;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abort_t1_re", 32'(mem_re), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    check("abort_t2_strb", {30'd0, mem_we, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    check("abort_t3_ready", 32'(bus.req_ready), 32'd1);
    check("abort_t3_strb", {30'd0, mem_we, bus.rsp_valid}, 32'd0);
    rst = 1'b0;
    run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd); check("lw_14_after_abort", rd, 32'h01020304);

    run_req(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, rd);
`ifdef DMEM_LSU_BOUNDS_CHECK_EN
    check("lw_2000_bounds", rd, 32'h0);
`else
    check("lw_2000_wrap", rd, init_word(0));
`endif

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFFE000) : 32'h0;
      a  = a | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_req(1'($urandom), sz, 1'($urandom), a, $urandom, rd);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
